alu_decode_exec: RTL and testbench

//  Execute-stage core of the RV32I single-cycle CPU: main control decode, ALU control decode and ALU datapath.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_decode_exec_if.sv | 41 ++++
 rtl/alu_core.sv | 36 +++
 rtl/alu_decode_exec.sv | 129 ++++++++++++
 tb/tb_alu_decode_exec.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the RV32I execute-stage decode/ALU slice.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_RTYPE = 2'b10,
        ALU_OP_ITYPE = 2'b11
    } alu_op_e;

    typedef enum logic [3:0] {
        ALU_AND    = 4'b0000,
        ALU_OR     = 4'b0001,
        ALU_ADD    = 4'b0010,
        ALU_XOR    = 4'b0011,
        ALU_SLL    = 4'b0100,
        ALU_SRL    = 4'b0101,
        ALU_SUB    = 4'b0110,
        ALU_SRA    = 4'b0111,
        ALU_SLT    = 4'b1000,
        ALU_SLTU   = 4'b1001,
        ALU_PASS_B = 4'b1010
    } alu_ctrl_e;

endpackage

// File: rtl/alu_decode_exec_if.sv
// Bus bundle between the instruction-field/operand source and the execute stage.
interface alu_decode_exec_if;
    import alu_pkg::*;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;

    logic            branch;
    logic            mem_read;
    logic            mem_to_reg;
    logic            mem_write;
    logic            alu_src;
    logic            reg_write;
    logic [1:0]      alu_op;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic            illegal;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic            reg_write_q;

    modport master (
        output opcode, funct3, funct7, rs1_data, rs2_data, imm,
        input  branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
        input  alu_op, alu_control, alu_result, alu_zero, illegal,
        input  result_q, zero_q, reg_write_q
    );

    modport slave (
        input  opcode, funct3, funct7, rs1_data, rs2_data, imm,
        output branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
        output alu_op, alu_control, alu_result, alu_zero, illegal,
        output result_q, zero_q, reg_write_q
    );

endinterface

// File: rtl/alu_core.sv
// Combinational 32-bit ALU: operation select, operands A/B -> result and zero flag.
module alu_core
    import alu_pkg::*;
(
    input  alu_ctrl_e       alu_control,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (alu_control)
            ALU_AND:    result = a & b;
            ALU_OR:     result = a | b;
            ALU_ADD:    result = a + b;
            ALU_XOR:    result = a ^ b;
            ALU_SLL:    result = a << shamt;
            ALU_SRL:    result = a >> shamt;
            ALU_SUB:    result = a - b;
            ALU_SRA:    result = $signed(a) >>> shamt;
            ALU_SLT:    result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:   result = {{(XLEN-1){1'b0}}, a < b};
            ALU_PASS_B: result = b;
            default:    result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_decode_exec.sv
// Execute-stage core: main control decode, ALU-control decode, ALU and a registered debug copy.
// Optional LUI support is enabled by defining ALU_LUI_EN.
module alu_decode_exec
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    alu_decode_exec_if.slave  bus
);

    alu_op_e         alu_op;
    alu_ctrl_e       alu_ctrl;
    logic            branch;
    logic            mem_read;
    logic            mem_to_reg;
    logic            mem_write;
    logic            alu_src;
    logic            reg_write;
    logic            illegal;
    logic [XLEN-1:0] operand_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    always_comb begin
        branch     = 1'b0;
        mem_read   = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        alu_op     = ALU_OP_ADD;
        case (bus.opcode)
            OP_R: begin
                reg_write = 1'b1;
                alu_op    = ALU_OP_RTYPE;
            end
            OP_I: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_op    = ALU_OP_ITYPE;
            end
            OP_LOAD: begin
                reg_write  = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                alu_src    = 1'b1;
            end
            OP_STORE: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
            end
            OP_BRANCH: begin
                branch = 1'b1;
                alu_op = ALU_OP_SUB;
            end
`ifdef ALU_LUI_EN
            OP_LUI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_op    = ALU_OP_ITYPE;
            end
`endif
            default: illegal = 1'b1;
        endcase
    end

    // funct7[5] selects SUB only for register ops; on I-type it is immediate bits, so ADDI stays ADD.
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_ctrl = ALU_ADD;
            ALU_OP_SUB: alu_ctrl = ALU_SUB;
            default: begin
                case (bus.funct3)
                    3'b000:  alu_ctrl = (alu_op == ALU_OP_RTYPE && bus.funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = bus.funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
        endcase
`ifdef ALU_LUI_EN
        if (bus.opcode == OP_LUI) begin
            alu_ctrl = ALU_PASS_B;
        end
`endif
    end

    assign operand_b = alu_src ? bus.imm : bus.rs2_data;

    alu_core u_core (
        .alu_control (alu_ctrl),
        .a           (bus.rs1_data),
        .b           (operand_b),
        .result      (alu_result),
        .zero        (alu_zero)
    );

    // Debug/display copy of the result; reset only touches these registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.result_q    <= '0;
            bus.zero_q      <= 1'b0;
            bus.reg_write_q <= 1'b0;
        end else begin
            bus.result_q    <= alu_result;
            bus.zero_q      <= alu_zero;
            bus.reg_write_q <= reg_write;
        end
    end

    assign bus.branch      = branch;
    assign bus.mem_read    = mem_read;
    assign bus.mem_to_reg  = mem_to_reg;
    assign bus.mem_write   = mem_write;
    assign bus.alu_src     = alu_src;
    assign bus.reg_write   = reg_write;
    assign bus.illegal     = illegal;
    assign bus.alu_op      = alu_op;
    assign bus.alu_control = alu_ctrl;
    assign bus.alu_result  = alu_result;
    assign bus.alu_zero    = alu_zero;

endmodule

// File: tb/tb_alu_decode_exec.sv
// Self-checking bench for alu_decode_exec: directed cases plus random vectors against an instruction-level model.
module tb_alu_decode_exec;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    alu_decode_exec_if bus ();

    alu_decode_exec dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // strb order: {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write}
    typedef struct packed {
        logic [5:0]  strb;
        logic        illegal;
        logic [1:0]  alu_op;
        logic [3:0]  ctrl;
        logic [31:0] result;
        logic        zero;
    } exp_t;

    function automatic logic [31:0] sra_ref(input logic [31:0] a, input logic [4:0] sh);
        logic [31:0] ones;
        logic [31:0] r;
        ones = 32'hFFFF_FFFF;
        r = a >> sh;
        if (a[31]) r = r | ~(ones >> sh);
        return r;
    endfunction

    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] a, input logic [31:0] r2, input logic [31:0] imm);
        exp_t        e;
        logic [31:0] b;
        logic        arith;
        e = '0;
        b = r2;
        arith = 1'b0;
        case (op)
            OP_R:      begin e.strb = 6'b000001; e.alu_op = 2'b10; arith = 1'b1; end
            OP_I:      begin e.strb = 6'b000011; e.alu_op = 2'b11; b = imm; arith = 1'b1; end
            OP_LOAD:   begin e.strb = 6'b011011; e.ctrl = 4'b0010; e.result = a + imm; end
            OP_STORE:  begin e.strb = 6'b000110; e.ctrl = 4'b0010; e.result = a + imm; end
            OP_BRANCH: begin e.strb = 6'b100000; e.alu_op = 2'b01; e.ctrl = 4'b0110; e.result = a - r2; end
`ifdef ALU_LUI_EN
            OP_LUI:    begin e.strb = 6'b000011; e.alu_op = 2'b11; e.ctrl = 4'b1010; e.result = imm; end
`endif
            default:   begin e.illegal = 1'b1; e.ctrl = 4'b0010; e.result = a + r2; end
        endcase
        if (arith) begin
            case (f3)
                3'd0: begin
                    if (op == OP_R && f7[5]) begin e.ctrl = 4'b0110; e.result = a - b; end
                    else begin e.ctrl = 4'b0010; e.result = a + b; end
                end
                3'd1: begin e.ctrl = 4'b0100; e.result = a << b[4:0]; end
                3'd2: begin e.ctrl = 4'b1000; e.result = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0; end
                3'd3: begin e.ctrl = 4'b1001; e.result = (a < b) ? 32'd1 : 32'd0; end
                3'd4: begin e.ctrl = 4'b0011; e.result = a ^ b; end
                3'd5: begin
                    if (f7[5]) begin e.ctrl = 4'b0111; e.result = sra_ref(a, b[4:0]); end
                    else begin e.ctrl = 4'b0101; e.result = a >> b[4:0]; end
                end
                3'd6: begin e.ctrl = 4'b0001; e.result = a | b; end
                default: begin e.ctrl = 4'b0000; e.result = a & b; end
            endcase
        end
        e.zero = (e.result == 32'd0);
        return e;
    endfunction

    task automatic set_inputs(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] a, input logic [31:0] r2, input logic [31:0] imm);
        @(negedge clk);
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.rs1_data = a;
        bus.rs2_data = r2;
        bus.imm      = imm;
        #1;
    endtask

    function automatic logic [5:0] strobes();
        return {bus.branch, bus.mem_read, bus.mem_to_reg, bus.mem_write, bus.alu_src, bus.reg_write};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        set_inputs(OP_R, 3'b000, 7'b0, 32'h5, 32'h3, 32'h0);
        @(posedge clk); #1;
        checks++; if (bus.result_q !== 32'h0) $display("[TB] FAIL reset_result_q got=%h exp=0", bus.result_q); else passed++;
        checks++; if (bus.zero_q !== 1'b0) $display("[TB] FAIL reset_zero_q got=%b exp=0", bus.zero_q); else passed++;
        checks++; if (bus.reg_write_q !== 1'b0) $display("[TB] FAIL reset_reg_write_q got=%b exp=0", bus.reg_write_q); else passed++;
        checks++; if (bus.alu_result !== 32'h8) $display("[TB] FAIL reset_comb_result got=%h exp=8", bus.alu_result); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_r_type();
        set_inputs(OP_R, 3'b000, 7'b0, 32'h5, 32'h3, 32'h77);
        checks++; if (bus.alu_control !== 4'b0010) $display("[TB] FAIL radd_ctrl got=%b exp=0010", bus.alu_control); else passed++;
        checks++; if (bus.alu_result !== 32'h8) $display("[TB] FAIL radd_result got=%h exp=8", bus.alu_result); else passed++;
        checks++; if (strobes() !== 6'b000001) $display("[TB] FAIL radd_strobes got=%b exp=000001", strobes()); else passed++;
        checks++; if (bus.alu_op !== 2'b10) $display("[TB] FAIL radd_alu_op got=%b exp=10", bus.alu_op); else passed++;
        @(posedge clk); #1;
        checks++; if (bus.result_q !== 32'h8) $display("[TB] FAIL radd_result_q got=%h exp=8", bus.result_q); else passed++;
        checks++; if (bus.reg_write_q !== 1'b1) $display("[TB] FAIL radd_reg_write_q got=%b exp=1", bus.reg_write_q); else passed++;
        set_inputs(OP_R, 3'b000, 7'b0100000, 32'h3, 32'h5, 32'h0);
        checks++; if (bus.alu_result !== 32'hFFFF_FFFE) $display("[TB] FAIL rsub_result got=%h exp=fffffffe", bus.alu_result); else passed++;
        checks++; if (bus.alu_zero !== 1'b0) $display("[TB] FAIL rsub_zero got=%b exp=0", bus.alu_zero); else passed++;
        set_inputs(OP_R, 3'b000, 7'b0100000, 32'h7, 32'h7, 32'h0);
        checks++; if (bus.alu_zero !== 1'b1) $display("[TB] FAIL rsub_eq_zero got=%b exp=1", bus.alu_zero); else passed++;
        @(posedge clk); #1;
        checks++; if (bus.zero_q !== 1'b1) $display("[TB] FAIL rsub_zero_q got=%b exp=1", bus.zero_q); else passed++;
    endtask

    task automatic test_i_type();
        set_inputs(OP_I, 3'b101, 7'b0100000, 32'h8000_0000, 32'h1F, 32'h4);
        checks++; if (bus.alu_result !== 32'hF800_0000) $display("[TB] FAIL srai_result got=%h exp=f8000000", bus.alu_result); else passed++;
        checks++; if (bus.alu_control !== 4'b0111) $display("[TB] FAIL srai_ctrl got=%b exp=0111", bus.alu_control); else passed++;
        set_inputs(OP_I, 3'b101, 7'b0000000, 32'h8000_0000, 32'h1F, 32'h4);
        checks++; if (bus.alu_result !== 32'h0800_0000) $display("[TB] FAIL srli_result got=%h exp=08000000", bus.alu_result); else passed++;
        set_inputs(OP_I, 3'b000, 7'b0100000, 32'h10, 32'h3, 32'h5);
        checks++; if (bus.alu_result !== 32'h15) $display("[TB] FAIL addi_f7_result got=%h exp=15", bus.alu_result); else passed++;
        checks++; if (bus.alu_control !== 4'b0010) $display("[TB] FAIL addi_f7_ctrl got=%b exp=0010", bus.alu_control); else passed++;
    endtask

    task automatic test_compare();
        set_inputs(OP_R, 3'b010, 7'b0, 32'hFFFF_FFFF, 32'h1, 32'h0);
        checks++; if (bus.alu_result !== 32'h1) $display("[TB] FAIL slt_result got=%h exp=1", bus.alu_result); else passed++;
        set_inputs(OP_R, 3'b011, 7'b0, 32'hFFFF_FFFF, 32'h1, 32'h0);
        checks++; if (bus.alu_result !== 32'h0) $display("[TB] FAIL sltu_result got=%h exp=0", bus.alu_result); else passed++;
    endtask

    task automatic test_mem_branch();
        set_inputs(OP_LOAD, 3'b010, 7'b0, 32'h100, 32'h9, 32'h20);
        checks++; if (strobes() !== 6'b011011) $display("[TB] FAIL load_strobes got=%b exp=011011", strobes()); else passed++;
        checks++; if (bus.alu_result !== 32'h120) $display("[TB] FAIL load_result got=%h exp=120", bus.alu_result); else passed++;
        set_inputs(OP_STORE, 3'b010, 7'b0, 32'h200, 32'h9, 32'h8);
        checks++; if (strobes() !== 6'b000110) $display("[TB] FAIL store_strobes got=%b exp=000110", strobes()); else passed++;
        checks++; if (bus.alu_result !== 32'h208) $display("[TB] FAIL store_result got=%h exp=208", bus.alu_result); else passed++;
        set_inputs(OP_BRANCH, 3'b000, 7'b0, 32'h9, 32'h4, 32'h40);
        checks++; if (bus.alu_op !== 2'b01) $display("[TB] FAIL branch_alu_op got=%b exp=01", bus.alu_op); else passed++;
        checks++; if (bus.alu_control !== 4'b0110) $display("[TB] FAIL branch_ctrl got=%b exp=0110", bus.alu_control); else passed++;
        checks++; if (strobes() !== 6'b100000) $display("[TB] FAIL branch_strobes got=%b exp=100000", strobes()); else passed++;
        checks++; if (bus.alu_result !== 32'h5) $display("[TB] FAIL branch_result got=%h exp=5", bus.alu_result); else passed++;
    endtask

    task automatic test_mid_reset();
        set_inputs(OP_R, 3'b000, 7'b0, 32'h1000, 32'h234, 32'h0);
        @(posedge clk); #1;
        checks++; if (bus.result_q !== 32'h1234) $display("[TB] FAIL midrst_pre_q got=%h exp=1234", bus.result_q); else passed++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (bus.result_q !== 32'h0) $display("[TB] FAIL midrst_result_q got=%h exp=0", bus.result_q); else passed++;
        checks++; if (bus.zero_q !== 1'b0) $display("[TB] FAIL midrst_zero_q got=%b exp=0", bus.zero_q); else passed++;
        checks++; if (bus.reg_write_q !== 1'b0) $display("[TB] FAIL midrst_reg_write_q got=%b exp=0", bus.reg_write_q); else passed++;
        checks++; if (bus.alu_result !== 32'h1234) $display("[TB] FAIL midrst_comb got=%h exp=1234", bus.alu_result); else passed++;
        @(posedge clk); #1;
        checks++; if (bus.result_q !== 32'h1234) $display("[TB] FAIL midrst_recover_q got=%h exp=1234", bus.result_q); else passed++;
    endtask

    task automatic test_lui();
        // funct3/funct7 are the upper immediate bits of the LUI instruction word.
        set_inputs(OP_LUI, 3'b101, 7'b0001001, 32'hAAAA_0000, 32'h1, 32'h1234_5000);
`ifdef ALU_LUI_EN
        checks++; if (bus.alu_result !== 32'h1234_5000) $display("[TB] FAIL lui_result got=%h exp=12345000", bus.alu_result); else passed++;
        checks++; if (bus.illegal !== 1'b0) $display("[TB] FAIL lui_illegal got=%b exp=0", bus.illegal); else passed++;
        checks++; if (strobes() !== 6'b000011) $display("[TB] FAIL lui_strobes got=%b exp=000011", strobes()); else passed++;
        checks++; if (bus.alu_control !== 4'b1010) $display("[TB] FAIL lui_ctrl got=%b exp=1010", bus.alu_control); else passed++;
`else
        checks++; if (bus.illegal !== 1'b1) $display("[TB] FAIL lui_illegal got=%b exp=1", bus.illegal); else passed++;
        checks++; if (strobes() !== 6'b000000) $display("[TB] FAIL lui_strobes got=%b exp=000000", strobes()); else passed++;
        checks++; if (bus.alu_op !== 2'b00) $display("[TB] FAIL lui_alu_op got=%b exp=00", bus.alu_op); else passed++;
`endif
    endtask

    task automatic test_random();
        logic [6:0]  ops [6];
        logic [6:0]  op;
        logic [31:0] a, r2, imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        exp_t        e;
        int          errs;
        ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LOAD;
        ops[3] = OP_STORE; ops[4] = OP_BRANCH; ops[5] = OP_LUI;
        for (int i = 0; i < 300; i++) begin
            op  = ($urandom_range(0, 7) < 6) ? ops[$urandom_range(0, 5)] : 7'($urandom);
            f3  = 3'($urandom);
            f7  = $urandom_range(0, 1) ? 7'b0100000 : 7'($urandom);
            a   = $urandom;
            r2  = $urandom;
            imm = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                r2 = a;
                imm = a;
            end
            e = model(op, f3, f7, a, r2, imm);
            set_inputs(op, f3, f7, a, r2, imm);
            errs = 0;
            checks++; if (strobes() !== e.strb) begin errs++; $display("[TB] FAIL rand_strobes op=%b got=%b exp=%b", op, strobes(), e.strb); end else passed++;
            checks++; if (bus.illegal !== e.illegal) begin errs++; $display("[TB] FAIL rand_illegal op=%b got=%b exp=%b", op, bus.illegal, e.illegal); end else passed++;
            checks++; if (bus.alu_op !== e.alu_op) begin errs++; $display("[TB] FAIL rand_alu_op op=%b got=%b exp=%b", op, bus.alu_op, e.alu_op); end else passed++;
            checks++; if (bus.alu_control !== e.ctrl) begin errs++; $display("[TB] FAIL rand_ctrl op=%b f3=%b f7=%b got=%b exp=%b", op, f3, f7, bus.alu_control, e.ctrl); end else passed++;
            checks++; if (bus.alu_result !== e.result) begin errs++; $display("[TB] FAIL rand_result op=%b f3=%b a=%h b=%h imm=%h got=%h exp=%h", op, f3, a, r2, imm, bus.alu_result, e.result); end else passed++;
            checks++; if (bus.alu_zero !== e.zero) begin errs++; $display("[TB] FAIL rand_zero got=%b exp=%b", bus.alu_zero, e.zero); end else passed++;
            @(posedge clk); #1;
            checks++; if (bus.result_q !== e.result) $display("[TB] FAIL rand_result_q got=%h exp=%h", bus.result_q, e.result); else passed++;
            checks++; if (bus.zero_q !== e.zero) $display("[TB] FAIL rand_zero_q got=%b exp=%b", bus.zero_q, e.zero); else passed++;
            checks++; if (bus.reg_write_q !== e.strb[0]) $display("[TB] FAIL rand_reg_write_q got=%b exp=%b", bus.reg_write_q, e.strb[0]); else passed++;
            if (errs > 20) break;
        end
    endtask

    initial begin
        bus.opcode   = '0;
        bus.funct3   = '0;
        bus.funct7   = '0;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        bus.imm      = '0;
        test_reset();
        test_r_type();
        test_i_type();
        test_compare();
        test_mem_branch();
        test_mid_reset();
        test_lui();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
